// File: rtl/dst40_fbank.sv
// Bank of N_CH 4-input truth-table functions, serially reloadable one channel at a time.
// One registered stage; operands stall (in_ready=0) while a table load is in flight or the output is blocked.
module dst40_fbank #(
    parameter int                  N_CH    = 7,
    parameter logic [16*N_CH-1:0]  TT_INIT = {N_CH{16'h724E}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_CH-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N_CH-1:0]       out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  cfg_start,
    input  logic [3:0]            cfg_ch,
    input  logic                  cfg_bit,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [4:0] N_CH_W   = 5'(N_CH);

    logic [1:0]      state;
    logic [3:0]      cnt;
    logic [3:0]      ch;
    logic [15:0]     shadow;
    logic [15:0]     tt [N_CH];
    logic            accept;
    logic            start_ok;
    logic [N_CH-1:0] lookup;

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign start_ok = cfg_start && ({1'b0, cfg_ch} < N_CH_W);
    assign cfg_busy = (state != S_IDLE);

    always_comb begin
        lookup = '0;
        for (int c = 0; c < N_CH; c++) begin
            lookup[c] = tt[c][in_data[4*c +: 4]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= lookup;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Tables live only in this block; a load fills the shadow and commits it in one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            ch       <= 4'd0;
            shadow   <= 16'd0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                tt[c] <= TT_INIT[16*c +: 16];
            end
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state     <= S_LOAD;
                        ch        <= cfg_ch;
                        cnt       <= 4'd0;
                        shadow[0] <= cfg_bit;
                    end else if (cfg_start) begin
                        cfg_err <= 1'b1;
                    end
                end
                S_LOAD: begin
                    shadow[cnt + 4'd1] <= cfg_bit;
                    cnt                <= cnt + 4'd1;
                    if (cnt == 4'd14) begin
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (ch == 4'(c)) begin
                            tt[c] <= shadow;
                        end
                    end
                    cfg_done <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
